axis_packet_gen: RTL and testbench

AXIS_PACKET_GEN -- requirements
Module: axis_packet_gen

---
 rtl/axis_packet_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_axis_packet_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_gen.sv
// AXI4-Stream packet generator: emits cfg_count packets of cfg_len beats with
// programmable inter-packet gaps and one of four data patterns.
module axis_packet_gen #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
    parameter int unsigned C_LEN_WIDTH        = 8,
    parameter int unsigned C_CNT_WIDTH        = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            start,
    input  logic                            abort,
    input  logic [C_LEN_WIDTH-1:0]          cfg_len,
    input  logic [C_CNT_WIDTH-1:0]          cfg_count,
    input  logic [C_LEN_WIDTH-1:0]          cfg_gap,
    input  logic [1:0]                      cfg_mode,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   cfg_seed,
    output logic                            busy,
    output logic                            done,
    output logic [C_CNT_WIDTH-1:0]          pkt_sent,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
);

    localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
    localparam int unsigned KW = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned LW = C_LEN_WIDTH;
    localparam int unsigned BW = C_LEN_WIDTH + 1;
    localparam int unsigned CW = C_CNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   last_idx_q, last_idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LW-1:0]   gap_q, gap_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   seed_q, seed_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [LW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            abort_q, abort_d;
    logic [CW-1:0]   pkt_sent_q, pkt_sent_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]   tkeep_q, tkeep_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            hs;
    logic [CW-1:0]   pkt_inc;

    // Data value of the beat that follows cur in the selected pattern
    function automatic logic [DW-1:0] next_data(
        input logic [1:0]    mode,
        input logic [DW-1:0] cur,
        input logic [DW-1:0] seed,
        input logic          is_last
    );
        logic [DW-1:0] nxt;
        case (mode)
            2'd0:    nxt = DW'(cur + DW'(1));
            2'd1:    nxt = seed;
            2'd2:    nxt = {cur[DW-2:0], cur[DW-1]};
            default: nxt = is_last ? seed : DW'(cur + DW'(1));
        endcase
        return nxt;
    endfunction

    assign hs      = tvalid_q & m_axis_tready;
    assign pkt_inc = CW'(pkt_sent_q + CW'(1));

    always_comb begin
        state_d    = state_q;
        last_idx_d = last_idx_q;
        count_d    = count_q;
        gap_d      = gap_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        beat_d     = beat_q;
        gap_cnt_d  = gap_cnt_q;
        abort_d    = abort_q;
        pkt_sent_d = pkt_sent_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_idx_d = (cfg_len == '0) ? '0 : BW'(BW'(cfg_len) - BW'(1));
                    count_d    = cfg_count;
                    gap_d      = cfg_gap;
                    mode_d     = cfg_mode;
                    seed_d     = cfg_seed;
                    beat_d     = '0;
                    abort_d    = 1'b0;
                    pkt_sent_d = '0;
                    tdata_d    = cfg_seed;
                    if (cfg_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = S_SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (cfg_len <= LW'(1));
                        busy_d   = 1'b1;
                    end
                end
            end

            S_SEND: begin
                abort_d = abort_q | abort;
                if (hs) begin
                    tdata_d = next_data(mode_q, tdata_q, seed_q, tlast_q);
                    if (tlast_q) begin
                        pkt_sent_d = pkt_inc;
                        beat_d     = '0;
                        if ((pkt_inc == count_q) || abort_q || abort) begin
                            state_d  = S_DONE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                        end else begin
                            tlast_d = (last_idx_q == '0);
                        end
                    end else begin
                        beat_d  = BW'(beat_q + BW'(1));
                        tlast_d = (BW'(beat_q + BW'(1)) == last_idx_q);
                    end
                end
            end

            S_GAP: begin
                // Abort during the gap ends the run without starting another packet
                if (abort_q || abort) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q <= LW'(1)) begin
                    state_d  = S_SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = (last_idx_q == '0);
                end else begin
                    gap_cnt_d = LW'(gap_cnt_q - LW'(1));
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase

        tkeep_d = {KW{tvalid_d}};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            last_idx_q <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            mode_q     <= '0;
            seed_q     <= '0;
            beat_q     <= '0;
            gap_cnt_q  <= '0;
            abort_q    <= 1'b0;
            pkt_sent_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            beat_q     <= beat_d;
            gap_cnt_q  <= gap_cnt_d;
            abort_q    <= abort_d;
            pkt_sent_q <= pkt_sent_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_sent      = pkt_sent_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tstrb  = tkeep_q;
    assign m_axis_tkeep  = tkeep_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed bench for axis_packet_gen: patterns, gaps, back-pressure, abort,
// empty runs and mid-packet reset, checked against hand-computed beats.
module tb_axis_packet_gen;

    localparam int unsigned W  = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 16;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic          abort;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_count;
    logic [LW-1:0] cfg_gap;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  cfg_seed;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_sent;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic [W/8-1:0] m_axis_tstrb;
    logic [W/8-1:0] m_axis_tkeep;
    logic          m_axis_tlast;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  beats[$];
    logic          lasts[$];
    int            gaps[$];
    logic          done_seen;
    int            done_lat;

    axis_packet_gen #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_LEN_WIDTH       (LW),
        .C_CNT_WIDTH       (CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .abort        (abort),
        .cfg_len      (cfg_len),
        .cfg_count    (cfg_count),
        .cfg_gap      (cfg_gap),
        .cfg_mode     (cfg_mode),
        .cfg_seed     (cfg_seed),
        .busy         (busy),
        .done         (done),
        .pkt_sent     (pkt_sent),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start with the given config, then scramble cfg_* so late changes are visible
    task automatic start_run(input logic [LW-1:0] len, input logic [CW-1:0] cnt,
                             input logic [LW-1:0] gap, input logic [1:0] mode,
                             input logic [W-1:0] seed);
        @(negedge aclk);
        cfg_len = len; cfg_count = cnt; cfg_gap = gap; cfg_mode = mode; cfg_seed = seed;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        cfg_len = 8'hFF; cfg_count = 16'hFFFF; cfg_gap = 8'h07;
        cfg_mode = ~mode; cfg_seed = ~seed;
    endtask

    // Drive tready from rdy_pat, record accepted beats, tlasts and gap lengths until done
    task automatic collect(input int max_cyc, input logic [31:0] rdy_pat, input int abort_beat);
        int         idle;
        int         last_hs;
        logic       in_gap;
        logic       prev_stall;
        logic [W-1:0] prev_d;
        beats.delete(); lasts.delete(); gaps.delete();
        done_seen = 1'b0; done_lat = -1;
        idle = 0; last_hs = -1; in_gap = 1'b0; prev_stall = 1'b0; prev_d = '0;
        for (int c = 0; c < max_cyc; c++) begin
            m_axis_tready = rdy_pat[c % 32];
            abort = (abort_beat >= 0) && (beats.size() == abort_beat) && m_axis_tvalid;
            if (done) begin
                done_seen = 1'b1;
                done_lat  = c - last_hs;
                break;
            end
            if (m_axis_tvalid) begin
                if (prev_stall) chk("stall_hold", 32'(m_axis_tdata), 32'(prev_d));
                if (in_gap) begin
                    gaps.push_back(idle);
                    in_gap = 1'b0;
                end
                if (m_axis_tready) begin
                    beats.push_back(m_axis_tdata);
                    lasts.push_back(m_axis_tlast);
                    chk("strb_keep", 32'({m_axis_tstrb, m_axis_tkeep}), 32'h3);
                    if (m_axis_tlast) begin
                        last_hs = c;
                        in_gap  = 1'b1;
                        idle    = 0;
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = m_axis_tdata;
                end
            end else if (in_gap) begin
                idle++;
            end
            @(negedge aclk);
        end
        m_axis_tready = 1'b1;
        abort = 1'b0;
        chk("done_seen", 32'(done_seen), 32'h1);
    endtask

    initial begin
        logic [W-1:0] e;
        int           act;

        aresetn = 1'b0; start = 1'b0; abort = 1'b0; m_axis_tready = 1'b1;
        cfg_len = '0; cfg_count = '0; cfg_gap = '0; cfg_mode = '0; cfg_seed = '0;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pkt_sent", 32'(pkt_sent), 32'h0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'h0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        // Single 5-beat packet, per-packet increment from 02
        start_run(8'd5, 16'd1, 8'd0, 2'd3, 8'h02);
        chk("t1_tvalid_first", 32'(m_axis_tvalid), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        collect(100, 32'hFFFF_FFFF, -1);
        chk("t1_nbeats", 32'(beats.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_data", 32'(beats[i]), 32'h02 + 32'(i));
            chk("t1_last", 32'(lasts[i]), (i == 4) ? 32'h1 : 32'h0);
        end
        chk("t1_done_lat", 32'(done_lat), 32'd1);
        chk("t1_pkt_sent", 32'(pkt_sent), 32'd1);
        chk("t1_busy_at_done", 32'(busy), 32'h0);
        @(negedge aclk);
        chk("t1_done_one_cycle", 32'(done), 32'h0);
        repeat (3) @(negedge aclk);
        chk("t1_pkt_sent_hold", 32'(pkt_sent), 32'd1);

        // Per-packet increment restarts at seed for each packet
        start_run(8'd3, 16'd2, 8'd1, 2'd3, 8'h10);
        collect(100, 32'hFFFF_FFFF, -1);
        chk("t1b_nbeats", 32'(beats.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t1b_data", 32'(beats[i]), 32'h10 + 32'(i % 3));

        // Three 4-beat packets, run-increment wrapping through 00, gap of 2
        start_run(8'd4, 16'd3, 8'd2, 2'd0, 8'hFE);
        collect(200, 32'hFFFF_FFFF, -1);
        chk("t2_nbeats", 32'(beats.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            e = 8'hFE + 8'(i);
            chk("t2_data", 32'(beats[i]), 32'(e));
            chk("t2_last", 32'(lasts[i]), (i % 4 == 3) ? 32'h1 : 32'h0);
        end
        chk("t2_ngaps", 32'(gaps.size()), 32'd2);
        chk("t2_gap0", 32'(gaps[0]), 32'd2);
        chk("t2_gap1", 32'(gaps[1]), 32'd2);
        chk("t2_pkt_sent", 32'(pkt_sent), 32'd3);

        // Rotate-left under irregular back-pressure, two 10-beat packets
        start_run(8'd10, 16'd2, 8'd0, 2'd2, 8'h01);
        collect(300, 32'hA5C3_6E19, -1);
        chk("t3_nbeats", 32'(beats.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            e = 8'h01 << (i % 8);
            chk("t3_data", 32'(beats[i]), 32'(e));
            chk("t3_last", 32'(lasts[i]), (i % 10 == 9) ? 32'h1 : 32'h0);
        end

        // Empty run: done pulse, no beat, pkt_sent cleared
        start_run(8'd4, 16'd0, 8'd0, 2'd0, 8'h55);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_pkt_sent", 32'(pkt_sent), 32'h0);
        @(negedge aclk);
        chk("t4_tvalid_after", 32'(m_axis_tvalid), 32'h0);

        // len=0 gives single-beat packets, back-to-back
        start_run(8'd0, 16'd3, 8'd0, 2'd1, 8'hA5);
        collect(100, 32'hFFFF_FFFF, -1);
        chk("t5_nbeats", 32'(beats.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_data", 32'(beats[i]), 32'hA5);
            chk("t5_last", 32'(lasts[i]), 32'h1);
        end
        chk("t5_gap0", 32'(gaps[0]), 32'd0);
        chk("t5_pkt_sent", 32'(pkt_sent), 32'd3);

        // Abort on beat 2 of the first of four packets
        start_run(8'd6, 16'd4, 8'd1, 2'd0, 8'h00);
        collect(200, 32'hFFFF_FFFF, 2);
        chk("t6_nbeats", 32'(beats.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t6_data", 32'(beats[i]), 32'(i));
        chk("t6_last", 32'(lasts[5]), 32'h1);
        chk("t6_done_lat", 32'(done_lat), 32'd1);
        chk("t6_pkt_sent", 32'(pkt_sent), 32'd1);

        // Reset mid-packet while stalled on beat 3
        start_run(8'd8, 16'd1, 8'd0, 2'd0, 8'h30);
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        m_axis_tready = 1'b0;
        chk("t7_beat3", 32'(m_axis_tdata), 32'h33);
        #2 aresetn = 1'b0;
        #1;
        chk("t7_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("t7_rst_busy", 32'(busy), 32'h0);
        chk("t7_rst_tlast", 32'(m_axis_tlast), 32'h0);
        chk("t7_rst_tdata", 32'(m_axis_tdata), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid || busy || done) act++;
        end
        chk("t7_idle_after_rst", 32'(act), 32'd0);

        // Fresh run after reset
        start_run(8'd2, 16'd1, 8'd0, 2'd0, 8'h40);
        collect(50, 32'hFFFF_FFFF, -1);
        chk("t8_nbeats", 32'(beats.size()), 32'd2);
        chk("t8_data0", 32'(beats[0]), 32'h40);
        chk("t8_data1", 32'(beats[1]), 32'h41);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
